ff_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single registered datapath stage (the one-flop `FF`-style capture register) between `N_REQ` requesters. Each cycle at most one requester's data is loaded into the shared register. The registered value is returned one cycle later, tagged with the winner's index, under a valid/ready response handshake. The block sits between independent producers and one shared register resource, and optionally carries inline SVA protocol checks.

---
 rtl/ff_share_arbiter.sv | 128 ++++++++++++
 tb/tb_ff_share_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter sharing one capture register among N_REQ requesters, with a valid/ready response.
// Define FF_SHARE_ARBITER_ASSERT_EN to compile in the inline SVA protocol checks.
module ff_share_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 1,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic                   rsp_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic [WIDTH-1:0]  data_arr [N_REQ];
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic              can_load;
    logic              acc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // Search starts just after the previous winner so every active requester
    // is reached within N_REQ accepts.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last_q) + off) % N_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    assign can_load = (state_q == ST_EMPTY) || rsp_ready;
    assign acc      = can_load && win_found;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        data_d  = data_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_FULL;
                    last_d  = win_idx;
                    id_d    = win_idx;
                    data_d  = data_arr[win_idx];
                end
            end
            ST_FULL: begin
                if (acc) begin
                    last_d  = win_idx;
                    id_d    = win_idx;
                    data_d  = data_arr[win_idx];
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Grant is Mealy and suppressed while reset is held so nothing is
    // handshaken into a register that cannot capture it.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = ASYNCRESETN && acc && (win_idx == ID_W'(i));
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= ST_EMPTY;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

`ifdef FF_SHARE_ARBITER_ASSERT_EN
    a_grant_onehot: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(req_ready));

    a_grant_fills: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (|req_ready) |-> ##1 rsp_valid);

    a_rsp_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (rsp_valid && !rsp_ready) |-> ##1 (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_hold
        a_valid_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            (req_valid[gi] && !req_ready[gi]) |-> ##1 req_valid[gi]);
    end
`endif

endmodule

// File: tb/tb_ff_share_arbiter.sv
// Self-checking bench for ff_share_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_ff_share_arbiter;

    localparam int N = 4;
    localparam int W = 1;

    logic           CLK;
    logic           ASYNCRESETN;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state: occupancy, held response, last winner.
    logic           m_full;
    logic [W-1:0]   m_data;
    int             m_id;
    int             m_last;
    int             last_grant;

    ff_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic int exp_winner(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = exp_winner(req_valid);
        if (ASYNCRESETN && (!m_full || rsp_ready) && w >= 0) return N'(1 << w);
        return '0;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_id   = 0;
        m_last = N - 1;
    endtask

    task automatic tick();
        int   w;
        logic acc;
        w   = exp_winner(req_valid);
        acc = ASYNCRESETN && (!m_full || rsp_ready) && (w >= 0);
        last_grant = acc ? w : -1;
        @(posedge CLK);
        if (acc) begin
            m_full = 1'b1;
            m_data = req_data[w*W +: W];
            m_id   = w;
            m_last = w;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        req_valid   = '0;
        model_reset();
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
    endtask

    task automatic test_reset();
        ASYNCRESETN = 1'b0;
        req_valid   = 4'b1111;
        req_data    = 4'b1111;
        rsp_ready   = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if ({req_ready, rsp_valid, rsp_id, rsp_data} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got ready=%b valid=%b id=%0d data=%b, required all 0",
                         c, req_ready, rsp_valid, rsp_id, rsp_data);
            end
        end
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL first_grant: got %b, required 0001", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL first_rsp: got valid=%b id=%0d, required valid=1 id=0", rsp_valid, rsp_id);
        end
        $display("test_reset done: first grant 0001, rsp_id %0d", rsp_id);
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        req_data  = 4'b1010;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] exp_r;
            exp_r = 4'b0001 << (k % 4);
            #1;
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rr_grant step %0d: got %b, required %b", k, req_ready, exp_r);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== 1'((k % 4) & 1)) begin
                errors++;
                $display("FAIL rr_rsp step %0d: got valid=%b id=%0d data=%b, required valid=1 id=%0d data=%0d",
                         k, rsp_valid, rsp_id, rsp_data, k % 4, (k % 4) & 1);
            end
            $display("rr step %0d: grant %b rsp_id %0d rsp_data %b", k, exp_r, rsp_id, rsp_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1111;
        req_data  = 4'b0100;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready cycle %0d: got %b, required 0000", k, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b id=%0d data=%b, required valid=1 id=2 data=1",
                         k, rsp_valid, rsp_id, rsp_data);
            end
            $display("bp cycle %0d: rsp_id %0d rsp_data %b", k, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release_grant: got %b, required 1000", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_rsp: got valid=%b id=%0d data=%b, required valid=1 id=3 data=0",
                     rsp_valid, rsp_id, rsp_data);
        end
        $display("bp release: rsp_id %0d", rsp_id);
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1'b1;
        req_data  = 4'b1001;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_g3: got %b, required 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_idle: got %b, required 0000", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd3 || rsp_data !== 1'b1) begin
            errors++;
            $display("FAIL wrap_drain: got valid=%b id=%0d data=%b, required valid=0 id=3 data=1",
                     rsp_valid, rsp_id, rsp_data);
        end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_g0: got %b, required 0001", req_ready);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_g3_again: got %b, required 1000", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd3 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_rsp: got valid=%b id=%0d, required valid=1 id=3", rsp_valid, rsp_id);
        end
        $display("wrap: grants 3,0,3 final rsp_id %0d", rsp_id);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b1111;
        req_data  = 4'b1111;
        rsp_ready = 1'b0;
        tick();
        tick();
        #2;
        ASYNCRESETN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_id !== 2'd0 || rsp_data !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got valid=%b ready=%b id=%0d data=%b, required all 0",
                     rsp_valid, req_ready, rsp_id, rsp_data);
        end
        req_valid = '0;
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
        rsp_ready   = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_replay: got valid=%b, required 0", rsp_valid);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_priority: got %b, required 0001", req_ready);
        end
        tick();
        $display("reset mid-transfer: post-release rsp_id %0d valid %b", rsp_id, rsp_valid);
    endtask

    task automatic test_random();
        int wait_cnt [N];
        do_reset();
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0] exp_r;
            logic [N-1:0] pend;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*W +: W] = W'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = exp_ready();
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rand_grant cyc %0d: got %b, required %b", cyc, req_ready, exp_r);
            end
            pend = req_valid;
            tick();
            checks++;
            if (rsp_valid !== m_full || rsp_id !== 2'(m_id) || rsp_data !== m_data) begin
                errors++;
                $display("FAIL rand_rsp cyc %0d: got valid=%b id=%0d data=%b, required valid=%b id=%0d data=%b",
                         cyc, rsp_valid, rsp_id, rsp_data, m_full, m_id, m_data);
            end
            if (last_grant >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i == last_grant) wait_cnt[i] = 0;
                    else if (pend[i]) wait_cnt[i]++;
                end
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (wait_cnt[i] > N - 1) begin
                        errors++;
                        $display("FAIL rand_fair req %0d: waited %0d accepts, required at most %0d",
                                 i, wait_cnt[i], N - 1);
                    end
                end
                req_valid[last_grant] = 1'b0;
            end
            $display("rand cyc %0d: valid=%b grant=%0d rsp_valid=%b rsp_id=%0d", cyc, pend, last_grant,
                     rsp_valid, rsp_id);
        end
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        last_grant  = -1;
        model_reset();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
